// File: rtl/traffic_light_controller.sv
// Free-running single-head traffic light sequencer (RED -> GREEN -> YELLOW -> RED).
// Define TLC_RED_YELLOW_EN to insert a RED+YELLOW aspect between RED and GREEN.
module traffic_light_controller #(
    parameter int unsigned RED_TICKS    = 16,
    parameter int unsigned GREEN_TICKS  = 16,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned RY_TICKS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] lights
);

    // A tick count of zero still holds the aspect for one cycle.
    localparam int unsigned R_DWELL  = (RED_TICKS    == 0) ? 1 : RED_TICKS;
    localparam int unsigned G_DWELL  = (GREEN_TICKS  == 0) ? 1 : GREEN_TICKS;
    localparam int unsigned Y_DWELL  = (YELLOW_TICKS == 0) ? 1 : YELLOW_TICKS;
    localparam int unsigned RY_DWELL = (RY_TICKS     == 0) ? 1 : RY_TICKS;

    localparam int unsigned MAX_RG   = (R_DWELL > G_DWELL) ? R_DWELL : G_DWELL;
    localparam int unsigned MAX_YRY  = (Y_DWELL > RY_DWELL) ? Y_DWELL : RY_DWELL;
    localparam int unsigned MAX_DW   = (MAX_RG > MAX_YRY) ? MAX_RG : MAX_YRY;
    localparam int unsigned CNT_W    = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;
`ifdef TLC_RED_YELLOW_EN
    localparam logic [2:0] L_RY     = 3'b110;
`endif

    typedef enum logic [1:0] {
        S_RED        = 2'd0,
        S_GREEN      = 2'd1,
`ifdef TLC_RED_YELLOW_EN
        S_YELLOW     = 2'd2,
        S_RED_YELLOW = 2'd3
`else
        S_YELLOW     = 2'd2
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         lights_q, lights_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RED;
            cnt_q    <= '0;
            lights_q <= L_RED;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lights_q <= lights_d;
        end
    end

    // Next state, dwell counter, and lamp decode of the upcoming state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        lights_d = L_RED;

        case (state_q)
            S_RED: begin
                if (cnt_q == CNT_W'(R_DWELL - 1)) begin
`ifdef TLC_RED_YELLOW_EN
                    state_d = S_RED_YELLOW;
`else
                    state_d = S_GREEN;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef TLC_RED_YELLOW_EN
            S_RED_YELLOW: begin
                if (cnt_q == CNT_W'(RY_DWELL - 1)) begin
                    state_d = S_GREEN;
                    cnt_d   = '0;
                end
            end
`endif
            S_GREEN: begin
                if (cnt_q == CNT_W'(G_DWELL - 1)) begin
                    state_d = S_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_YELLOW: begin
                if (cnt_q == CNT_W'(Y_DWELL - 1)) begin
                    state_d = S_RED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RED;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            S_GREEN:      lights_d = L_GREEN;
            S_YELLOW:     lights_d = L_YELLOW;
`ifdef TLC_RED_YELLOW_EN
            S_RED_YELLOW: lights_d = L_RY;
`endif
            default:      lights_d = L_RED;
        endcase
    end

    assign lights = lights_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default, 1/1/1 and 1/1/0 tick builds.
// Follows TLC_RED_YELLOW_EN to pick the expected aspect sequence.
module tb_traffic_light_controller;

`ifdef TLC_RED_YELLOW_EN
    localparam int PERIOD      = 38;
    localparam int SPERIOD     = 4;
    localparam int GREEN_START = 18;
`else
    localparam int PERIOD      = 36;
    localparam int SPERIOD     = 3;
    localparam int GREEN_START = 16;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] l_def, l_one, l_zero;

    int total = 0;
    int bad   = 0;
    int pos   = 0;
    int spos  = 0;
    int edge_no = 0;
    int last_green = -1;
    logic [2:0] prev = 3'b100;

    always #5 clk = ~clk;

    traffic_light_controller dut_def (
        .clk    (clk),
        .rst    (rst),
        .lights (l_def)
    );

    traffic_light_controller #(
        .RED_TICKS(1), .GREEN_TICKS(1), .YELLOW_TICKS(1), .RY_TICKS(1)
    ) dut_one (
        .clk    (clk),
        .rst    (rst),
        .lights (l_one)
    );

    traffic_light_controller #(
        .RED_TICKS(1), .GREEN_TICKS(1), .YELLOW_TICKS(0), .RY_TICKS(0)
    ) dut_zero (
        .clk    (clk),
        .rst    (rst),
        .lights (l_zero)
    );

    function automatic logic [2:0] exp_def(input int p);
`ifdef TLC_RED_YELLOW_EN
        if (p < 16)      return 3'b100;
        else if (p < 18) return 3'b110;
        else if (p < 34) return 3'b001;
        else             return 3'b010;
`else
        if (p < 16)      return 3'b100;
        else if (p < 32) return 3'b001;
        else             return 3'b010;
`endif
    endfunction

    function automatic logic [2:0] exp_small(input int p);
`ifdef TLC_RED_YELLOW_EN
        case (p)
            0:       return 3'b100;
            1:       return 3'b110;
            2:       return 3'b001;
            default: return 3'b010;
        endcase
`else
        case (p)
            0:       return 3'b100;
            1:       return 3'b001;
            default: return 3'b010;
        endcase
`endif
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, edge_no, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_no, got, exp);
        end
    endtask

    task automatic reset_edge();
        rst = 1'b1;
        @(posedge clk);
        #1;
        edge_no++;
        pos = 0;
        spos = 0;
        last_green = -1;
        check("rst_def", l_def, 3'b100);
        check("rst_one", l_one, 3'b100);
        check("rst_zero", l_zero, 3'b100);
        prev = l_def;
    endtask

    task automatic run(input int n);
        logic legal;
        rst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_no++;
            pos  = (pos + 1) % PERIOD;
            spos = (spos + 1) % SPERIOD;
            check("seq_def", l_def, exp_def(pos));
            check("seq_one", l_one, exp_small(spos));
            check("seq_zero", l_zero, exp_small(spos));
`ifdef TLC_RED_YELLOW_EN
            legal = (l_def != 3'b000) && !(l_def[0] && (l_def[2:1] != 2'b00));
`else
            legal = $onehot(l_def);
`endif
            check_int("legal_def", int'(legal), 1);
            if (l_def == 3'b001 && prev != 3'b001) begin
                if (last_green >= 0)
                    check_int("period", edge_no - last_green, PERIOD);
                last_green = edge_no;
            end
            prev = l_def;
        end
    endtask

    initial begin
        rst = 1'b1;
        reset_edge();
        reset_edge();

        // Walk the first full period, then keep running to 500 cycles.
        run(GREEN_START - 1);
        check("still_red", l_def, 3'b100);
        run(1);
        check("first_green", l_def, 3'b001);
        run(PERIOD - GREEN_START);
        check("red_again", l_def, 3'b100);
        run(500 - PERIOD);

        // Reset at count 7 of GREEN.
        run((GREEN_START + 7 - pos + PERIOD) % PERIOD);
        check("pre_rst_green", l_def, 3'b001);
        reset_edge();
        run(GREEN_START - 1);
        check("post_rst_red", l_def, 3'b100);
        run(1);
        check("post_rst_green", l_def, 3'b001);
        run(10);

        // Long reset hold.
        repeat (20) reset_edge();
        run(GREEN_START - 1);
        check("hold_red", l_def, 3'b100);
        run(1);
        check("hold_green", l_def, 3'b001);
        run(2 * PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
